// File: rtl/mult_axil_pkg.sv
// Shared register map, response codes and core state for the multiplier front-end.
package mult_axil_pkg;

  localparam logic [7:0] ADDR_OPA    = 8'h00;
  localparam logic [7:0] ADDR_OPB    = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_RES_LO = 8'h10;
  localparam logic [7:0] ADDR_RES_HI = 8'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} core_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_axil_front_wr_join.sv
// AW/W one-entry holding registers; the write fires in the cycle both halves are present.
module axil_wr_join #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  input  logic              b_pending,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb
);

  logic              aw_full, w_full;
  logic [ADDR_W-1:0] aw_q;
  logic [31:0]       w_q;
  logic [3:0]        s_q;
  logic              aw_take, w_take;

  assign awready = !rst && !aw_full && !b_pending;
  assign wready  = !rst && !w_full && !b_pending;
  assign aw_take = awvalid && awready;
  assign w_take  = wvalid && wready;

  // A half arriving this cycle joins directly with one already held.
  assign wr_en   = !rst && (aw_full || aw_take) && (w_full || w_take);
  assign wr_addr = aw_full ? aw_q : awaddr;
  assign wr_data = w_full ? w_q : wdata;
  assign wr_strb = w_full ? s_q : wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      s_q     <= '0;
    end else if (wr_en) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_take) begin
        aw_full <= 1'b1;
        aw_q    <= awaddr;
      end
      if (w_take) begin
        w_full <= 1'b1;
        w_q    <= wdata;
        s_q    <= wstrb;
      end
    end
  end

endmodule

// File: rtl/mult_axil_front.sv
// AXI4-Lite register front-end for the mult core: operands, start pulse, status and result.
module mult_axil_front
  import mult_axil_pkg::*;
#(
  parameter int SZ     = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [SZ-1:0]     m_a,
  output logic [SZ-1:0]     m_b,
  output logic              m_start,
  input  logic [2*SZ-1:0]   m_res,
  input  logic              m_ready
);

  localparam logic [31:0] OP_MASK = 32'((64'd1 << SZ) - 64'd1);

  core_state_t       state;
  logic [31:0]       opa, opb;
  logic [63:0]       res;
  logic              done, busy, ready_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp, rd_resp;
  logic [31:0]       rd_data;
  logic              start_req, start_ok;

  axil_wr_join #(.ADDR_W(ADDR_W)) u_wr_join (
    .clk       (clk),
    .rst       (_rst),
    .awaddr    (s_awaddr),
    .awvalid   (s_awvalid),
    .awready   (s_awready),
    .wdata     (s_wdata),
    .wstrb     (s_wstrb),
    .wvalid    (s_wvalid),
    .wready    (s_wready),
    .b_pending (s_bvalid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb)
  );

  assign s_arready = !_rst && !s_rvalid;
  assign m_a       = opa[SZ-1:0];
  assign m_b       = opb[SZ-1:0];
  assign start_req = wr_en && (wr_addr == ADDR_W'(ADDR_CTRL)) && wr_data[0] && wr_strb[0];
  assign start_ok  = start_req && (state != BUSY);

  always_comb begin
    wr_resp = RESP_SLVERR;
    if (wr_addr == ADDR_W'(ADDR_OPA) || wr_addr == ADDR_W'(ADDR_OPB))
      wr_resp = RESP_OKAY;
    else if (wr_addr == ADDR_W'(ADDR_CTRL))
      wr_resp = (start_req && state == BUSY) ? RESP_SLVERR : RESP_OKAY;
  end

  always_comb begin
    rd_data = 32'd0;
    rd_resp = RESP_OKAY;
    case (s_araddr)
      ADDR_W'(ADDR_OPA):    rd_data = opa;
      ADDR_W'(ADDR_OPB):    rd_data = opb;
      ADDR_W'(ADDR_CTRL):   rd_data = 32'd0;
      ADDR_W'(ADDR_STATUS): rd_data = {30'd0, busy, done};
      ADDR_W'(ADDR_RES_LO): rd_data = res[31:0];
      ADDR_W'(ADDR_RES_HI): rd_data = res[63:32];
      default:              rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (_rst) begin
      opa      <= '0;
      opb      <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
      s_rvalid <= 1'b0;
      s_rresp  <= RESP_OKAY;
      s_rdata  <= '0;
    end else begin
      if (wr_en) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_resp;
        if (wr_addr == ADDR_W'(ADDR_OPA)) opa <= apply_strb(opa, wr_data, wr_strb) & OP_MASK;
        if (wr_addr == ADDR_W'(ADDR_OPB)) opb <= apply_strb(opb, wr_data, wr_strb) & OP_MASK;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_data;
        s_rresp  <= rd_resp;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // Only a rising edge of m_ready while BUSY completes; a level left over from the last run is ignored.
  always_ff @(posedge clk) begin
    if (_rst) begin
      state   <= IDLE;
      m_start <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      res     <= '0;
      ready_q <= 1'b0;
    end else begin
      m_start <= 1'b0;
      ready_q <= m_ready;
      case (state)
        IDLE, DONE: if (start_ok) begin
          state   <= BUSY;
          m_start <= 1'b1;
          done    <= 1'b0;
          busy    <= 1'b1;
        end
        BUSY: if (m_ready && !ready_q) begin
          state <= DONE;
          res   <= 64'(m_res);
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_axil_front.sv
// Directed bench for mult_axil_front with a behavioural mult that answers 5 cycles after start.
module tb_mult_axil_front;
  import mult_axil_pkg::*;

  logic        clk = 1'b0;
  logic        _rst;
  logic [4:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] m_a, m_b;
  logic        m_start;
  logic [63:0] m_res   = 64'd0;
  logic        m_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_axil_front #(.SZ(32), .ADDR_W(5)) dut (
    .clk(clk), ._rst(_rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_a(m_a), .m_b(m_b), .m_start(m_start), .m_res(m_res), .m_ready(m_ready)
  );

  // Multiplier stand-in: drops ready on start, raises it with the product 5 cycles later.
  int          mcnt = 0;
  logic [31:0] ma_q = 32'd0, mb_q = 32'd0;
  always @(posedge clk) begin
    if (m_start) begin
      mcnt    <= 5;
      m_ready <= 1'b0;
      ma_q    <= m_a;
      mb_q    <= m_b;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        m_ready <= 1'b1;
        m_res   <= 64'(ma_q) * 64'(mb_q);
      end
    end
  end

  int          start_cnt = 0;
  logic [31:0] start_a = 32'd0, start_b = 32'd0;
  always @(negedge clk) begin
    if (m_start) begin
      start_cnt <= start_cnt + 1;
      start_a   <= m_a;
      start_b   <= m_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    s_bready = 1'b1;
    while (!s_bvalid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b_timeout", s_bvalid, 1);
    resp = s_bresp;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_ok = 0;
    bit w_ok  = 0;
    int n = 0;
    @(negedge clk);
    s_awaddr = addr[4:0]; s_awvalid = 1'b1;
    s_wdata  = data;      s_wstrb   = strb; s_wvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < 20) begin
      #1;
      if (s_awvalid && s_awready) aw_ok = 1;
      if (s_wvalid && s_wready) w_ok = 1;
      @(negedge clk);
      if (aw_ok) s_awvalid = 1'b0;
      if (w_ok) s_wvalid = 1'b0;
      n++;
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    check("wr_accept", {aw_ok, w_ok}, 2'b11);
    check("b_latency", s_bvalid, 1);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ok = 0;
    int n = 0;
    @(negedge clk);
    s_araddr = addr[4:0]; s_arvalid = 1'b1;
    while (!ok && n < 20) begin
      #1;
      if (s_arready) ok = 1;
      @(negedge clk);
      n++;
    end
    s_arvalid = 1'b0;
    check("ar_accept", ok, 1);
    check("r_latency", s_rvalid, 1);
    data = s_rdata;
    resp = s_rresp;
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] addr,
                          input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(tag, {r, d}, {exp_r, exp_d});
  endtask

  task automatic wr_check(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_r);
    logic [1:0] r;
    axi_write(addr, data, strb, r);
    check(tag, r, exp_r);
  endtask

  task automatic wait_done();
    logic [31:0] d;
    logic [1:0]  r;
    int n = 0;
    do begin
      axi_read(ADDR_STATUS, d, r);
      n++;
    end while (d != 32'h1 && n < 20);
    check("done_status", d, 32'h1);
  endtask

  int s0;

  initial begin
    _rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", {s_bvalid, s_bresp}, 0);
    check("rst_rvalid", {s_rvalid, s_rresp, s_rdata}, 0);
    check("rst_mst", {m_start, m_a, m_b}, 0);
    _rst = 1'b0;
    @(negedge clk);
    rd_check("rst_status", ADDR_STATUS, 32'h0, RESP_OKAY);
    rd_check("rst_res_lo", ADDR_RES_LO, 32'h0, RESP_OKAY);

    // 7 * 6
    wr_check("wr_opa", ADDR_OPA, 32'd7, 4'hF, RESP_OKAY);
    wr_check("wr_opb", ADDR_OPB, 32'd6, 4'hF, RESP_OKAY);
    wr_check("wr_ctrl", ADDR_CTRL, 32'd1, 4'hF, RESP_OKAY);
    check("start_once", start_cnt, 1);
    check("start_ops", {start_a, start_b}, {32'd7, 32'd6});
    rd_check("status_busy", ADDR_STATUS, 32'h2, RESP_OKAY);
    wait_done();
    check("start_still_once", start_cnt, 1);
    rd_check("res_lo_42", ADDR_RES_LO, 32'd42, RESP_OKAY);
    rd_check("res_hi_42", ADDR_RES_HI, 32'd0, RESP_OKAY);

    // Full-scale operands
    wr_check("wr_opa_max", ADDR_OPA, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
    wr_check("wr_opb_max", ADDR_OPB, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
    rd_check("rd_opa_max", ADDR_OPA, 32'hFFFF_FFFF, RESP_OKAY);
    wr_check("wr_ctrl_max", ADDR_CTRL, 32'd1, 4'h1, RESP_OKAY);
    wait_done();
    rd_check("res_lo_max", ADDR_RES_LO, 32'h0000_0001, RESP_OKAY);
    rd_check("res_hi_max", ADDR_RES_HI, 32'hFFFF_FFFE, RESP_OKAY);

    // AW three cycles ahead of W, B held off for two cycles
    @(negedge clk);
    s_awaddr = 5'h00; s_awvalid = 1'b1;
    #1 check("split_awready", s_awready, 1);
    @(negedge clk);
    s_awvalid = 1'b0;
    #1 check("split_aw_held", s_awready, 0);
    repeat (2) @(negedge clk);
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    #1 check("split_wready", s_wready, 1);
    check("split_no_early_b", s_bvalid, 0);
    @(negedge clk);
    s_wvalid = 1'b0;
    s_awaddr = 5'h04; s_awvalid = 1'b1;
    repeat (2) begin
      #1 check("split_b_stable", {s_bvalid, s_bresp}, {1'b1, RESP_OKAY});
      check("split_no_aw", s_awready, 0);
      @(negedge clk);
    end
    s_bready = 1'b1;
    #1 check("split_no_aw_hs", s_awready, 0);
    @(negedge clk);
    s_bready = 1'b0;
    s_awvalid = 1'b0;
    #1 check("split_aw_after_b", {s_awready, s_bvalid}, 2'b10);
    rd_check("split_opa", ADDR_OPA, 32'h1234_5678, RESP_OKAY);
    rd_check("split_opb_untouched", ADDR_OPB, 32'hFFFF_FFFF, RESP_OKAY);

    // Error paths and byte strobes
    wr_check("wr_res_ro", ADDR_RES_LO, 32'h5555_5555, 4'hF, RESP_SLVERR);
    rd_check("res_lo_kept", ADDR_RES_LO, 32'h0000_0001, RESP_OKAY);
    wr_check("wr_status_ro", ADDR_STATUS, 32'h3, 4'hF, RESP_SLVERR);
    rd_check("rd_unmapped", 8'h18, 32'h0, RESP_SLVERR);
    wr_check("wr_unmapped", 8'h1C, 32'h1, 4'hF, RESP_SLVERR);
    rd_check("rd_ctrl_zero", ADDR_CTRL, 32'h0, RESP_OKAY);
    wr_check("wr_opb_zero", ADDR_OPB, 32'h0, 4'hF, RESP_OKAY);
    wr_check("wr_opb_strb", ADDR_OPB, 32'hAABB_CCDD, 4'b0001, RESP_OKAY);
    rd_check("opb_strb", ADDR_OPB, 32'h0000_00DD, RESP_OKAY);
    wr_check("wr_opb_strb_hi", ADDR_OPB, 32'hAABB_CCDD, 4'b1000, RESP_OKAY);
    rd_check("opb_strb_hi", ADDR_OPB, 32'hAA00_00DD, RESP_OKAY);

    // CTRL bit0=0 is a no-op; a start while busy is refused
    s0 = start_cnt;
    wr_check("ctrl_zero", ADDR_CTRL, 32'h0, 4'hF, RESP_OKAY);
    wr_check("ctrl_no_strb", ADDR_CTRL, 32'h1, 4'b0010, RESP_OKAY);
    check("ctrl_zero_no_start", start_cnt, s0);
    wr_check("wr_opa_3", ADDR_OPA, 32'd3, 4'hF, RESP_OKAY);
    wr_check("wr_opb_5", ADDR_OPB, 32'd5, 4'hF, RESP_OKAY);
    wr_check("ctrl_start", ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
    wr_check("ctrl_busy", ADDR_CTRL, 32'h1, 4'hF, RESP_SLVERR);
    wr_check("opa_while_busy", ADDR_OPA, 32'd9, 4'hF, RESP_OKAY);
    repeat (2) @(negedge clk);
    check("busy_single_start", start_cnt, s0 + 1);
    wait_done();
    rd_check("res_busy_run", ADDR_RES_LO, 32'd15, RESP_OKAY);
    wr_check("ctrl_restart", ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
    wait_done();
    rd_check("res_new_opa", ADDR_RES_LO, 32'd45, RESP_OKAY);

    // Reset during BUSY, then the multiplier answers anyway
    wr_check("ctrl_pre_rst", ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
    @(negedge clk);
    _rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_ready", {s_awready, s_arready, s_bvalid, s_rvalid}, 4'b0000);
    _rst = 1'b0;
    repeat (12) @(negedge clk);
    rd_check("post_rst_status", ADDR_STATUS, 32'h0, RESP_OKAY);
    rd_check("post_rst_res_lo", ADDR_RES_LO, 32'h0, RESP_OKAY);
    rd_check("post_rst_res_hi", ADDR_RES_HI, 32'h0, RESP_OKAY);
    rd_check("post_rst_opa", ADDR_OPA, 32'h0, RESP_OKAY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
